// File: rtl/i2c_slave_rx_if.sv
// Bus-side and user-side signals of the I2C target, grouped so the target
// and its environment connect through one port.
interface i2c_slave_rx_if;
  logic       scl;       // bus SCL level
  logic       sda_in;    // bus SDA level
  logic       sda_oe;    // 1 = pull SDA low, 0 = release
  logic [7:0] rx_data;   // last byte written by the master
  logic       rx_valid;  // one-cycle strobe: rx_data is new
  logic [7:0] tx_data;   // byte to return on a read
  logic       tx_req;    // one-cycle strobe: tx_data is captured this cycle
  logic       rw;        // R/W bit of the current addressed transfer
  logic       busy;      // high from START to STOP

  modport slave (
    input  scl, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, rw, busy
  );

  modport master (
    output scl, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, rw, busy
  );
endinterface

// File: rtl/i2c_slave_rx.sv
// Byte-oriented I2C target: oversamples SCL/SDA, detects START/STOP, ACKs a
// fixed 7-bit address, streams written bytes out and shifts read bytes in
// from the user. SDA is open-drain via sda_oe; SCL is never stretched.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h55
) (
  input  logic          sys_clk,
  input  logic          rst,
  i2c_slave_rx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  // Input conditioning
  logic [1:0] r_scl_sync;
  logic       r_scl_hist;
  logic [1:0] r_sda_sync;
  logic       r_sda_hist;

  // Protocol state
  state_t     r_state;
  logic [3:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [7:0] r_tx_shift;
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_req;
  logic       r_rw;
  logic       r_busy;

  // Next-state values
  state_t     w_state_nxt;
  logic [3:0] w_bit_cnt_nxt;
  logic [6:0] w_shift_nxt;
  logic [7:0] w_tx_shift_nxt;
  logic       w_sda_oe_nxt;
  logic [7:0] w_rx_data_nxt;
  logic       w_rx_valid_nxt;
  logic       w_tx_req_nxt;
  logic       w_rw_nxt;
  logic       w_busy_nxt;

  logic       w_scl;
  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_sda_rise;
  logic       w_sda_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign w_scl_rise = w_scl & ~r_scl_hist;
  assign w_scl_fall = ~w_scl & r_scl_hist;
  assign w_sda_rise = w_sda & ~r_sda_hist;
  assign w_sda_fall = ~w_sda & r_sda_hist;
  assign w_start    = w_sda_fall & w_scl;
  assign w_stop     = w_sda_rise & w_scl;
  // Byte as it stands once the current SDA sample is shifted in
  assign w_byte     = {r_shift, w_sda};

  // Two-flop synchronizers plus history flop; idle bus level is 1
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and the chain really delays by one cycle each.
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_scl_hist <= 1'b1;
      r_sda_sync <= 2'b11;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], bus.scl};
      r_scl_hist <= r_scl_sync[1];
      r_sda_sync <= {r_sda_sync[0], bus.sda_in};
      r_sda_hist <= r_sda_sync[1];
    end
  end

  // Protocol state register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 7'd0;
      r_tx_shift <= 8'd0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_req   <= w_tx_req_nxt;
      r_rw       <= w_rw_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Next-state and output logic; START/STOP override the bit-level logic
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    // The user's byte is captured in the cycle tx_req is high; SCL is
    // stable high then, so no shift can collide with this load.
    w_tx_shift_nxt = r_tx_req ? bus.tx_data : r_tx_shift;
    w_sda_oe_nxt   = r_sda_oe;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_req_nxt   = 1'b0;
    w_rw_nxt       = r_rw;
    w_busy_nxt     = r_busy;

    if (w_start) begin
      w_state_nxt   = S_ADDR;
      w_bit_cnt_nxt = 4'd0;
      w_busy_nxt    = 1'b1;
      w_sda_oe_nxt  = 1'b0;
    end else if (w_stop) begin
      w_state_nxt   = S_IDLE;
      w_busy_nxt    = 1'b0;
      w_sda_oe_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: ;

        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte[6:0];
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_rw_nxt      = w_byte[0];
              w_bit_cnt_nxt = 4'd0;
              if (w_byte[7:1] == SLAVE_ADDR) begin
                w_state_nxt  = S_ADDR_ACK;
                w_tx_req_nxt = w_byte[0];
              end else begin
                w_state_nxt  = S_IGNORE;
              end
            end
          end
        end

        // First fall pulls SDA low for the ACK clock; second fall ends it
        S_ADDR_ACK, S_WR_ACK: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 4'd0) begin
              w_sda_oe_nxt  = 1'b1;
              w_bit_cnt_nxt = 4'd1;
            end else if (r_state == S_ADDR_ACK && r_rw) begin
              w_sda_oe_nxt   = ~r_tx_shift[7];
              w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
              w_bit_cnt_nxt  = 4'd1;
              w_state_nxt    = S_RD_DATA;
            end else begin
              w_sda_oe_nxt  = 1'b0;
              w_bit_cnt_nxt = 4'd0;
              w_state_nxt   = S_WR_DATA;
            end
          end
        end

        S_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte[6:0];
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_rx_data_nxt  = w_byte;
              w_rx_valid_nxt = 1'b1;
              w_bit_cnt_nxt  = 4'd0;
              w_state_nxt    = S_WR_ACK;
            end
          end
        end

        // bit_cnt counts bits already driven; after eight, release for ACK
        S_RD_DATA: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_oe_nxt  = 1'b0;
              w_bit_cnt_nxt = 4'd0;
              w_state_nxt   = S_RD_ACK;
            end else begin
              w_sda_oe_nxt   = ~r_tx_shift[7];
              w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
              w_bit_cnt_nxt  = r_bit_cnt + 4'd1;
            end
          end
        end

        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_tx_req_nxt  = 1'b1;
              w_bit_cnt_nxt = 4'd0;
              w_state_nxt   = S_RD_DATA;
            end else begin
              w_state_nxt   = S_IGNORE;
            end
          end
        end

        S_IGNORE: w_sda_oe_nxt = 1'b0;

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.sda_oe   = r_sda_oe;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.tx_req   = r_tx_req;
  assign bus.rw       = r_rw;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a bit-banged I2C master drives the bus,
// expected written and read bytes are queued when stimulus is issued and
// compared when the target produces them.
module tb_i2c_slave_rx;

  localparam int Q = 20;  // sys_clk cycles per quarter SCL period

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic m_scl   = 1'b1;
  logic m_sda   = 1'b1;

  i2c_slave_rx_if bus();

  assign bus.scl    = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  i2c_slave_rx #(.SLAVE_ADDR(7'h55)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int         total     = 0;
  int         bad       = 0;
  int         rx_cnt    = 0;
  int         txreq_cnt = 0;
  logic       oe_seen   = 1'b0;
  logic [7:0] q_rx[$];
  logic [7:0] q_rd[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: strobe counting and written-byte scoreboard, away from the edge
  always @(negedge sys_clk) begin
    int n;
    if (bus.sda_oe) oe_seen = 1'b1;
    if (bus.tx_req) txreq_cnt++;
    if (bus.rx_valid) begin
      rx_cnt++;
      n = q_rx.size();
      check("rx_pending", n > 0, 1);
      if (n > 0) check("rx_data", bus.rx_data, q_rx.pop_front());
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge sys_clk);
  endtask

  task automatic clock_bit(input logic b, output logic smp_sda, output logic smp_oe);
    m_sda = b;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    smp_sda = bus.sda_in;
    smp_oe  = bus.sda_oe;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  // Also serves as repeated START when entered with SCL low
  task automatic i2c_start();
    m_sda = 1'b1;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b1;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic s, o;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s, o);
    clock_bit(1'b1, s, o);
    check({tag, "_ack"}, s, exp_ack);
    check({tag, "_oe"}, o, !exp_ack);
  endtask

  task automatic read_byte(input logic ack, input string tag);
    logic       s, o;
    logic [7:0] d;
    int         n;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s, o);
      d[i] = s;
    end
    clock_bit(ack, s, o);
    check({tag, "_ackslot_oe"}, o, 0);
    n = q_rd.size();
    check({tag, "_pending"}, n > 0, 1);
    if (n > 0) check({tag, "_data"}, d, q_rd.pop_front());
  endtask

  initial begin
    int rx_base, tx_base;
    bus.tx_data = 8'h00;

    // Reset values
    repeat (4) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_tx_req", bus.tx_req, 0);
    check("rst_rw", bus.rw, 0);
    check("rst_busy", bus.busy, 0);
    wait_q();

    // Write 0x3C to 0x55
    rx_base = rx_cnt;
    i2c_start();
    check("w_busy", bus.busy, 1);
    q_rx.push_back(8'h3C);
    write_byte(8'hAA, 1'b0, "w_addr");
    check("w_rw", bus.rw, 0);
    write_byte(8'h3C, 1'b0, "w_data");
    i2c_stop();
    check("w_busy_end", bus.busy, 0);
    check("w_rx_count", rx_cnt - rx_base, 1);
    check("w_rx_hold", bus.rx_data, 8'h3C);

    // Address mismatch: never ACKed, nothing written
    rx_base = rx_cnt;
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h54, 1'b1, "m_addr");
    write_byte(8'h3C, 1'b1, "m_data");
    check("m_busy", bus.busy, 1);
    i2c_stop();
    check("m_busy_end", bus.busy, 0);
    check("m_oe_seen", oe_seen, 0);
    check("m_rx_count", rx_cnt - rx_base, 0);

    // Single-byte read of 0xA5, master NACK
    tx_base = txreq_cnt;
    bus.tx_data = 8'hA5;
    q_rd.push_back(8'hA5);
    i2c_start();
    write_byte(8'hAB, 1'b0, "r_addr");
    check("r_rw", bus.rw, 1);
    read_byte(1'b1, "r_b0");
    wait_q();
    check("r_after_oe", bus.sda_oe, 0);
    i2c_stop();
    check("r_txreq_count", txreq_cnt - tx_base, 1);

    // Two-byte read: 0x12 ACKed, then 0x34 NACKed
    tx_base = txreq_cnt;
    bus.tx_data = 8'h12;
    q_rd.push_back(8'h12);
    i2c_start();
    write_byte(8'hAB, 1'b0, "r2_addr");
    bus.tx_data = 8'h34;
    q_rd.push_back(8'h34);
    read_byte(1'b0, "r2_b0");
    read_byte(1'b1, "r2_b1");
    i2c_stop();
    check("r2_txreq_count", txreq_cnt - tx_base, 2);

    // Write 0x3C, repeated START, read 0xA5
    rx_base = rx_cnt;
    i2c_start();
    q_rx.push_back(8'h3C);
    write_byte(8'hAA, 1'b0, "sr_waddr");
    write_byte(8'h3C, 1'b0, "sr_wdata");
    i2c_start();
    check("sr_busy", bus.busy, 1);
    bus.tx_data = 8'hA5;
    q_rd.push_back(8'hA5);
    write_byte(8'hAB, 1'b0, "sr_raddr");
    check("sr_rw", bus.rw, 1);
    read_byte(1'b1, "sr_b0");
    i2c_stop();
    check("sr_rx_count", rx_cnt - rx_base, 1);
    check("sr_busy_end", bus.busy, 0);

    // Reset while the target pulls SDA low for bit 7 of 0x00
    bus.tx_data = 8'h00;
    i2c_start();
    write_byte(8'hAB, 1'b0, "rr_addr");
    check("rr_pre_oe", bus.sda_oe, 1);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    check("rr_post_oe", bus.sda_oe, 0);
    check("rr_post_busy", bus.busy, 0);
    wait_q();

    // Fresh write after the reset
    rx_base = rx_cnt;
    i2c_start();
    q_rx.push_back(8'h3C);
    write_byte(8'hAA, 1'b0, "rw_addr");
    write_byte(8'h3C, 1'b0, "rw_data");
    i2c_stop();
    check("rw_rx_count", rx_cnt - rx_base, 1);
    check("rw_rx_data", bus.rx_data, 8'h3C);

    wait_q();
    check("end_rx_queue", q_rx.size(), 0);
    check("end_rd_queue", q_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
